id_ex_skid_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 66 ++++++
 rtl/pipe_slot.sv | 30 +++
 rtl/id_ex_skid_reg.sv | 173 +++++++++++++++++
 tb/tb_id_ex_skid_reg.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the decode->execute pipeline register.
//   ctrl_t        - decoded control bundle that travels with each instruction
//   CTRL_W        - width of ctrl_t
//   skid_state_t  - occupancy state of the 2-entry skid buffer
//   payload_w / off_* helpers - payload layout, MSB first:
//     {r1, r2, imm, pc, pc_plus_4, r1_num, r2_num, dr_num}
package pipe_pkg;

  typedef struct packed {
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic       branch;
    logic [3:0] alu_control;
    logic       mem_read;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Payload layout helpers. Offsets are LSB positions of each field.
  function automatic int unsigned payload_w(input int unsigned xlen, input int unsigned reg_w);
    return 5 * xlen + 3 * reg_w;
  endfunction

  function automatic int unsigned off_dr_num(input int unsigned xlen, input int unsigned reg_w);
    return 0 * xlen + 0 * reg_w;
  endfunction

  function automatic int unsigned off_r2_num(input int unsigned xlen, input int unsigned reg_w);
    return 0 * xlen + 1 * reg_w;
  endfunction

  function automatic int unsigned off_r1_num(input int unsigned xlen, input int unsigned reg_w);
    return 0 * xlen + 2 * reg_w;
  endfunction

  function automatic int unsigned off_pc_plus_4(input int unsigned xlen,
                                                input int unsigned reg_w);
    return 0 * xlen + 3 * reg_w;
  endfunction

  function automatic int unsigned off_pc(input int unsigned xlen, input int unsigned reg_w);
    return 1 * xlen + 3 * reg_w;
  endfunction

  function automatic int unsigned off_imm(input int unsigned xlen, input int unsigned reg_w);
    return 2 * xlen + 3 * reg_w;
  endfunction

  function automatic int unsigned off_r2(input int unsigned xlen, input int unsigned reg_w);
    return 3 * xlen + 3 * reg_w;
  endfunction

  function automatic int unsigned off_r1(input int unsigned xlen, input int unsigned reg_w);
    return 4 * xlen + 3 * reg_w;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the skid buffer: a W-bit register with load enable and
// synchronous clear (clear has priority).
//   clk     - clock, rising edge
//   i_clr   - synchronous clear to zero
//   i_load  - capture i_d
//   i_d     - next contents
//   o_q     - current contents
module pipe_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/id_ex_skid_reg.sv
// Decode->execute pipeline register built as a 2-entry skid buffer with
// valid/ready handshakes on both sides, flush, bubble control zeroing,
// occupancy reporting and a saturating upstream-stall counter.
//   clk          - clock, rising edge
//   reset_n      - synchronous active-low reset
//   flush        - kill all buffered entries (branch/jump redirect)
//   in_valid     - upstream entry valid
//   in_ready     - stage can accept (registered, no comb path from inputs)
//   in_data      - payload {r1, r2, imm, pc, pc_plus_4, r1_num, r2_num, dr_num}
//   in_ctrl      - control bundle
//   out_valid    - head entry presented to execute
//   out_ready    - execute consumes head entry
//   out_data     - payload of head (main) register
//   out_ctrl     - control of head, zeroed on bubbles if CLEAR_ON_BUBBLE
//   occupancy    - entries held (0..2)
//   stall_cycles - saturating count of cycles upstream was held off
module id_ex_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned REG_W           = 5,
  parameter int unsigned CNT_W           = 16,
  parameter bit          CLEAR_ON_BUBBLE = 1'b1,
  localparam int unsigned DATA_W         = 5 * XLEN + 3 * REG_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  ctrl_t             in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output ctrl_t             out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned SLOT_W = DATA_W + CTRL_W;

  skid_state_t      r_state;
  skid_state_t      w_state_nxt;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_stall_cycles;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_load;
  logic              w_main_from_skid;
  logic              w_skid_load;
  logic              w_clr;
  logic [SLOT_W-1:0] w_in_slot;
  logic [SLOT_W-1:0] w_main_d;
  logic [SLOT_W-1:0] w_main_q;
  logic [SLOT_W-1:0] w_skid_q;
  ctrl_t             w_main_ctrl;

  assign w_clr     = ~reset_n;
  assign w_in_slot = {in_data, in_ctrl};

  assign out_valid  = (r_state != EMPTY);
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Next-state and slot load decode. Flush wins over every handshake and
  // suppresses all loads so the killed entries' payload stays as stale data.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ONE;
            w_main_load = 1'b1;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_load = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
          end else if (w_in_fire) begin
            w_state_nxt = FULL;
            w_skid_load = 1'b1;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            w_state_nxt      = ONE;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != FULL);
    end
  end

  // Counts cycles upstream offered an entry that was refused; a flush cycle
  // is not a stall because the offered entry is being killed anyway.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
    end else if (in_valid && !r_in_ready && !flush && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : w_in_slot;

  pipe_slot #(
    .W (SLOT_W)
  ) u_main_slot (
    .clk    (clk),
    .i_clr  (w_clr),
    .i_load (w_main_load),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  pipe_slot #(
    .W (SLOT_W)
  ) u_skid_slot (
    .clk    (clk),
    .i_clr  (w_clr),
    .i_load (w_skid_load),
    .i_d    (w_in_slot),
    .o_q    (w_skid_q)
  );

  assign out_data    = w_main_q[SLOT_W-1:CTRL_W];
  assign w_main_ctrl = ctrl_t'(w_main_q[CTRL_W-1:0]);

  always_comb begin
    out_ctrl = w_main_ctrl;
    if (CLEAR_ON_BUBBLE && !out_valid) begin
      out_ctrl = '0;
    end
  end

  always_comb begin
    occupancy = 2'd0;
    unique case (r_state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign in_ready     = r_in_ready;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
module tb_id_ex_skid_reg;
  import pipe_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned DATA_W  = 5 * XLEN + 3 * REG_W;
  localparam int unsigned OFF_R1  = off_r1(XLEN, REG_W);
  localparam int unsigned OFF_R2  = off_r2(XLEN, REG_W);
  localparam int unsigned OFF_IMM = off_imm(XLEN, REG_W);
  localparam int unsigned OFF_PC  = off_pc(XLEN, REG_W);
  localparam int unsigned OFF_PC4 = off_pc_plus_4(XLEN, REG_W);
  localparam int unsigned OFF_R1N = off_r1_num(XLEN, REG_W);
  localparam int unsigned OFF_R2N = off_r2_num(XLEN, REG_W);
  localparam int unsigned OFF_DRN = off_dr_num(XLEN, REG_W);

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  ctrl_t             in_ctrl;
  logic              out_ready;

  logic              a_in_ready, b_in_ready;
  logic              a_out_valid, b_out_valid;
  logic [DATA_W-1:0] a_out_data, b_out_data;
  ctrl_t             a_out_ctrl, b_out_ctrl;
  logic [1:0]        a_occ, b_occ;
  logic [15:0]       a_stall;
  logic [3:0]        b_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_skid_reg dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (a_in_ready),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .out_valid    (a_out_valid),
    .out_ready    (out_ready),
    .out_data     (a_out_data),
    .out_ctrl     (a_out_ctrl),
    .occupancy    (a_occ),
    .stall_cycles (a_stall)
  );

  id_ex_skid_reg #(
    .CNT_W           (4),
    .CLEAR_ON_BUBBLE (1'b0)
  ) dut_b (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (b_in_ready),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .out_valid    (b_out_valid),
    .out_ready    (out_ready),
    .out_data     (b_out_data),
    .out_ctrl     (b_out_ctrl),
    .occupancy    (b_occ),
    .stall_cycles (b_stall)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input logic [XLEN-1:0] pc);
    logic [DATA_W-1:0] d;
    d = '0;
    d[OFF_R1 +: XLEN]   = pc ^ 32'hA5A5_0000;
    d[OFF_R2 +: XLEN]   = pc ^ 32'h5A5A_0000;
    d[OFF_IMM +: XLEN]  = pc >> 2;
    d[OFF_PC +: XLEN]   = pc;
    d[OFF_PC4 +: XLEN]  = pc + 32'd4;
    d[OFF_R1N +: REG_W] = pc[6:2];
    d[OFF_R2N +: REG_W] = pc[7:3];
    d[OFF_DRN +: REG_W] = pc[8:4];
    return d;
  endfunction

  function automatic ctrl_t mk_ctrl(input logic [XLEN-1:0] pc);
    ctrl_t c;
    c             = '0;
    c.reg_write   = 1'b1;
    c.alu_control = pc[5:2];
    c.branch      = pc[2];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] pc);
    in_valid = v;
    in_data  = mk_data(pc);
    in_ctrl  = mk_ctrl(pc);
  endtask

  task automatic expect_head(input string tag, input logic [XLEN-1:0] pc);
    check({tag, "_valid"}, 256'(a_out_valid), 256'(1'b1));
    check({tag, "_data"}, 256'(a_out_data), 256'(mk_data(pc)));
    check({tag, "_ctrl"}, 256'(a_out_ctrl), 256'(mk_ctrl(pc)));
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h50);

    // Reset held two cycles with in_valid asserted.
    tick();
    tick();
    check("rst_valid", 256'(a_out_valid), 256'(1'b0));
    check("rst_ready", 256'(a_in_ready), 256'(1'b0));
    check("rst_ctrl", 256'(a_out_ctrl), 256'(0));
    check("rst_ctrl_b", 256'(b_out_ctrl), 256'(0));
    check("rst_data", 256'(a_out_data), 256'(0));
    check("rst_occ", 256'(a_occ), 256'(0));
    check("rst_stall", 256'(a_stall), 256'(0));

    reset_n = 1'b1;
    drive(1'b0, 32'h0);
    tick();
    check("rel_ready", 256'(a_in_ready), 256'(1'b1));
    check("rel_valid", 256'(a_out_valid), 256'(1'b0));
    check("rel_stall", 256'(a_stall), 256'(0));

    // Streaming with out_ready high: one-cycle latency, occupancy 1.
    out_ready = 1'b1;
    drive(1'b1, 32'h100);
    tick();
    expect_head("s100", 32'h100);
    check("s100_occ", 256'(a_occ), 256'(1));
    drive(1'b1, 32'h104);
    tick();
    expect_head("s104", 32'h104);
    check("s104_occ", 256'(a_occ), 256'(1));
    drive(1'b1, 32'h108);
    tick();
    expect_head("s108", 32'h108);
    check("s108_occ", 256'(a_occ), 256'(1));
    drive(1'b0, 32'h0);
    tick();
    check("drain_valid", 256'(a_out_valid), 256'(1'b0));
    check("bubble_ctrl", 256'(a_out_ctrl), 256'(0));
    check("bubble_ctrl_keep", 256'(b_out_ctrl), 256'(mk_ctrl(32'h108)));
    check("bubble_regw_keep", 256'(b_out_ctrl.reg_write), 256'(1'b1));
    check("bubble_data", 256'(a_out_data), 256'(mk_data(32'h108)));

    // Back-pressure: two entries absorbed, third held upstream.
    out_ready = 1'b0;
    drive(1'b1, 32'h200);
    tick();
    expect_head("bp200", 32'h200);
    check("bp200_ready", 256'(a_in_ready), 256'(1'b1));
    drive(1'b1, 32'h204);
    tick();
    check("bp_full_occ", 256'(a_occ), 256'(2));
    check("bp_full_ready", 256'(a_in_ready), 256'(1'b0));
    expect_head("bp_full", 32'h200);
    drive(1'b1, 32'h208);
    tick();
    check("bp_stall1", 256'(a_stall), 256'(1));
    expect_head("bp_hold", 32'h200);
    tick();
    check("bp_stall2", 256'(a_stall), 256'(2));
    check("bp_stall2_b", 256'(b_stall), 256'(2));
    out_ready = 1'b1;
    tick();
    expect_head("bp204", 32'h204);
    check("bp204_occ", 256'(a_occ), 256'(1));
    check("bp_stall3", 256'(a_stall), 256'(3));
    check("bp204_ready", 256'(a_in_ready), 256'(1'b1));
    tick();
    expect_head("bp208", 32'h208);
    drive(1'b0, 32'h0);
    tick();
    check("bp_empty", 256'(a_occ), 256'(0));

    // Flush while FULL with a new entry offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h300);
    tick();
    drive(1'b1, 32'h304);
    tick();
    check("fl_pre_occ", 256'(a_occ), 256'(2));
    drive(1'b1, 32'h308);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid", 256'(a_out_valid), 256'(1'b0));
    check("fl_occ", 256'(a_occ), 256'(0));
    check("fl_ctrl", 256'(a_out_ctrl), 256'(0));
    check("fl_ready", 256'(a_in_ready), 256'(1'b1));
    check("fl_stale_data", 256'(a_out_data), 256'(mk_data(32'h300)));
    check("fl_stale_ctrl_b", 256'(b_out_ctrl), 256'(mk_ctrl(32'h300)));
    check("fl_stall", 256'(a_stall), 256'(3));
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    tick();
    check("fl_after_valid", 256'(a_out_valid), 256'(1'b0));
    drive(1'b1, 32'h30C);
    tick();
    expect_head("fl_30c", 32'h30C);

    // Saturation: fill and hold upstream for 20 cycles.
    out_ready = 1'b0;
    drive(1'b1, 32'h400);
    tick();
    check("sat_occ", 256'(a_occ), 256'(2));
    for (int i = 0; i < 20; i++) tick();
    check("sat_a", 256'(a_stall), 256'(23));
    check("sat_b", 256'(b_stall), 256'(15));
    tick();
    tick();
    check("sat_a2", 256'(a_stall), 256'(25));
    check("sat_b_hold", 256'(b_stall), 256'(15));
    expect_head("sat_head", 32'h30C);

    // Flush coinciding with out_fire from FULL.
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    check("flo_occ", 256'(a_occ), 256'(0));
    tick();
    check("flo_valid", 256'(a_out_valid), 256'(1'b0));

    // Reset mid-operation.
    out_ready = 1'b0;
    drive(1'b1, 32'h500);
    tick();
    expect_head("mr500", 32'h500);
    reset_n = 1'b0;
    tick();
    check("mr_occ", 256'(a_occ), 256'(0));
    check("mr_data", 256'(a_out_data), 256'(0));
    check("mr_stall", 256'(a_stall), 256'(0));
    check("mr_ready", 256'(a_in_ready), 256'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
